// File: rtl/sn184_bcd2bin_seq.sv
// sn184_bcd2bin_seq: multi-cycle BCD-to-binary converter (reverse double-dabble).
// A packed DIGITS-digit BCD word is shifted right one bit per clock. After each
// shift, any BCD digit >= 8 has 3 subtracted. After BIN_W shifts, the low field
// holds the binary value.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    conversion request, sampled only in IDLE
//   g_n      active-low output enable; 1 forces bin_out to all ones
//   bcd_in   packed BCD input (digit 0 = bits [3:0]), sampled with start
//   bin_out  binary result (or all ones when g_n = 1)
//   busy     high while shifting
//   done     one-cycle pulse when bin_out/err become valid
//   err      last accepted request held a digit > 9
module sn184_bcd2bin_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  g_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    result_q, result_d;
    logic                err_q, err_d;

    logic [WORK_W-1:0]   step_c;
    logic                bad_digit_c;

    // Any input digit outside 0..9 marks the request invalid.
    always_comb begin
        bad_digit_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit_c = 1'b1;
            end
        end
    end

    // One iteration: shift right, then correct each BCD digit that is >= 8.
    always_comb begin
        logic [3:0] dig;
        step_c = work_q >> 1;
        dig    = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = step_c[BIN_W + 4*i +: 4];
            if (dig >= 4'd8) begin
                step_c[BIN_W + 4*i +: 4] = dig - 4'd3;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (bad_digit_c) begin
                        err_d    = 1'b1;
                        result_d = '1;
                        state_d  = ST_DONE;
                    end else begin
                        work_d  = {bcd_in, BIN_W'(0)};
                        cnt_d   = CNT_W'(0);
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    result_d = step_c[BIN_W-1:0];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    // The output enable acts only on the output; it never feeds back into state.
    assign bin_out = g_n ? '1 : result_q;

endmodule
